// File: rtl/alu_regfile.sv
// alu_regfile: RV32I integer datapath core. A 32x32 register file with two
// combinational read ports and one synchronous write port feeds a purely
// combinational ALU. ALU operand A is always read port 1.
// Optional build macro ALU_REGFILE_BYPASS_EN enables write-through
// forwarding of rf_indata onto rv1/rv2 during a same-cycle write.
module alu_regfile #(
  parameter int NUM_REGS = 32,
  parameter int ERR_CODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] rf_indata,
  input  logic        regwrite,
  output logic [31:0] rv1,
  output logic [31:0] rv2,
  input  logic [5:0]  op,
  input  logic [31:0] in2,
  input  logic [4:0]  shamt,
  output logic [31:0] out,
  output logic [31:0] x31
);

  localparam logic [5:0] OP_ADDI  = 6'b000000;
  localparam logic [5:0] OP_SLTI  = 6'b000001;
  localparam logic [5:0] OP_SLTIU = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b000100;
  localparam logic [5:0] OP_ANDI  = 6'b000101;
  localparam logic [5:0] OP_SLLI  = 6'b000110;
  localparam logic [5:0] OP_SRLI  = 6'b000111;
  localparam logic [5:0] OP_SRAI  = 6'b001000;
  localparam logic [5:0] OP_ADD   = 6'b001001;
  localparam logic [5:0] OP_SUB   = 6'b001010;
  localparam logic [5:0] OP_SLL   = 6'b001011;
  localparam logic [5:0] OP_SLT   = 6'b001100;
  localparam logic [5:0] OP_SLTU  = 6'b001101;
  localparam logic [5:0] OP_XOR   = 6'b001110;
  localparam logic [5:0] OP_SRL   = 6'b001111;
  localparam logic [5:0] OP_SRA   = 6'b010000;
  localparam logic [5:0] OP_OR    = 6'b010001;
  localparam logic [5:0] OP_AND   = 6'b010010;

  logic [31:0] regs [NUM_REGS];
  logic [31:0] stored1;
  logic [31:0] stored2;
  logic        wr_active;

  // A write takes effect only when not in reset and not targeting x0.
  assign wr_active = regwrite && !reset && (rd != 5'd0);

  // Register storage: synchronous clear has priority over the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[rd] <= rf_indata;
    end
  end

  // x0 is hardwired to zero regardless of what the array holds.
  assign stored1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign stored2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

`ifdef ALU_REGFILE_BYPASS_EN
  // wr_active already excludes x0, so index 0 can never be forwarded.
  assign rv1 = (wr_active && (rd == rs1)) ? rf_indata : stored1;
  assign rv2 = (wr_active && (rd == rs2)) ? rf_indata : stored2;
`else
  assign rv1 = stored1;
  assign rv2 = stored2;
`endif

  // ALU: decode op into a result and an illegal-op code on x31.
  always_comb begin
    out = 32'd0;
    x31 = 32'd0;
    unique case (op)
      OP_ADDI, OP_ADD: out = rv1 + in2;
      OP_SUB:          out = rv1 - in2;
      OP_SLTI, OP_SLT: out = {31'd0, ($signed(rv1) < $signed(in2))};
      OP_SLTIU, OP_SLTU: out = {31'd0, (rv1 < in2)};
      OP_XORI, OP_XOR: out = rv1 ^ in2;
      OP_ORI, OP_OR:   out = rv1 | in2;
      OP_ANDI, OP_AND: out = rv1 & in2;
      OP_SLLI:         out = rv1 << shamt;
      OP_SRLI:         out = rv1 >> shamt;
      OP_SRAI:         out = $unsigned($signed(rv1) >>> shamt);
      OP_SLL:          out = rv1 << in2[4:0];
      OP_SRL:          out = rv1 >> in2[4:0];
      OP_SRA:          out = $unsigned($signed(rv1) >>> in2[4:0]);
      default: begin
        out = 32'd0;
        x31 = 32'(ERR_CODE);
      end
    endcase
  end

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed self-checking bench for alu_regfile.
module tb_alu_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rf_indata;
  logic        regwrite;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [5:0]  op;
  logic [31:0] in2;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic [31:0] x31;

  int n_checks = 0;
  int n_fail   = 0;

  alu_regfile #(.NUM_REGS(32), .ERR_CODE(1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rf_indata(rf_indata), .regwrite(regwrite), .rv1(rv1), .rv2(rv2),
    .op(op), .in2(in2), .shamt(shamt), .out(out), .x31(x31)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One write through the port; inputs change 1 ns after the edge.
  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    rd = idx; rf_indata = data; regwrite = 1'b1;
    @(posedge clk); #1;
    regwrite = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [4:0] src, input logic [5:0] o,
                     input logic [31:0] b, input logic [4:0] sh,
                     input logic [31:0] exp_out, input logic [31:0] exp_x31);
    rs1 = src; op = o; in2 = b; shamt = sh;
    #1;
    check({tag, "_out"}, out, exp_out);
    check({tag, "_x31"}, x31, exp_x31);
  endtask

  initial begin
    logic [31:0] exp_fwd;
    reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; rf_indata = '0;
    regwrite = 1'b0; op = 6'b001001; in2 = 32'h0000_1234; shamt = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd31; #1;
    check("rst_rv1", rv1, 32'd0);
    check("rst_rv2", rv2, 32'd0);
    rs1 = 5'd0; #1;
    check("idle_out", out, 32'h0000_1234);
    check("idle_x31", x31, 32'd0);

    // x0 discards writes
    wr(5'd0, 32'hDEAD_BEEF);
    rs1 = 5'd0; #1;
    check("x0_write", rv1, 32'd0);

    // Basic write/read
    wr(5'd5, 32'h0000_0007);
    wr(5'd6, 32'hFFFF_FFF9);
    rs1 = 5'd5; rs2 = 5'd6; #1;
    check("rd_x5", rv1, 32'h0000_0007);
    check("rd_x6", rv2, 32'hFFFF_FFF9);

    // Same-cycle read during write of x5
`ifdef ALU_REGFILE_BYPASS_EN
    exp_fwd = 32'h0000_0009;
`else
    exp_fwd = 32'h0000_0007;
`endif
    rd = 5'd5; rf_indata = 32'h0000_0009; regwrite = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5; #1;
    check("wr_same_rv1", rv1, exp_fwd);
    check("wr_same_rv2", rv2, exp_fwd);
    @(posedge clk); #1;
    regwrite = 1'b0; #1;
    check("wr_after", rv1, 32'h0000_0009);

    // x0 is never forwarded
    rd = 5'd0; rf_indata = 32'h0000_00FF; regwrite = 1'b1; rs1 = 5'd0; #1;
    check("x0_nofwd", rv1, 32'd0);
    @(posedge clk); #1;
    regwrite = 1'b0;

    // Arithmetic
    wr(5'd7, 32'h7FFF_FFFF);
    alu("add",  5'd7, 6'b001001, 32'd1, 5'd0, 32'h8000_0000, 32'd0);
    alu("addi", 5'd7, 6'b000000, 32'd1, 5'd0, 32'h8000_0000, 32'd0);
    alu("sub",  5'd0, 6'b001010, 32'd1, 5'd0, 32'hFFFF_FFFF, 32'd0);

    // Compares
    wr(5'd8, 32'hFFFF_FFFF);
    alu("slt",    5'd8, 6'b001100, 32'd1, 5'd0, 32'd1, 32'd0);
    alu("slti",   5'd8, 6'b000001, 32'd1, 5'd0, 32'd1, 32'd0);
    alu("sltu",   5'd8, 6'b001101, 32'd1, 5'd0, 32'd0, 32'd0);
    alu("sltiu",  5'd8, 6'b000010, 32'd1, 5'd0, 32'd0, 32'd0);
    alu("slt_eq", 5'd8, 6'b001100, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0);
    alu("sltu_eq",5'd8, 6'b001101, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0);
    alu("sltu_lt",5'd5, 6'b001101, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0);

    // Shifts
    wr(5'd9, 32'h8000_0010);
    alu("srai", 5'd9, 6'b001000, 32'd0, 5'd4, 32'hF800_0001, 32'd0);
    alu("srli", 5'd9, 6'b000111, 32'd0, 5'd4, 32'h0800_0001, 32'd0);
    alu("slli", 5'd9, 6'b000110, 32'd0, 5'd4, 32'h0000_0100, 32'd0);
    alu("sll",  5'd9, 6'b001011, 32'h0000_0021, 5'd0, 32'h0000_0020, 32'd0);
    alu("sra",  5'd9, 6'b010000, 32'h0000_0024, 5'd0, 32'hF800_0001, 32'd0);
    alu("srl",  5'd9, 6'b001111, 32'h0000_0024, 5'd0, 32'h0800_0001, 32'd0);

    // Logic ops, x5 holds 9
    alu("xor",  5'd5, 6'b001110, 32'h0000_000F, 5'd0, 32'h0000_0006, 32'd0);
    alu("xori", 5'd5, 6'b000011, 32'h0000_000F, 5'd0, 32'h0000_0006, 32'd0);
    alu("or",   5'd5, 6'b010001, 32'h0000_0006, 5'd0, 32'h0000_000F, 32'd0);
    alu("ori",  5'd5, 6'b000100, 32'h0000_0006, 5'd0, 32'h0000_000F, 32'd0);
    alu("and",  5'd5, 6'b010010, 32'h0000_0003, 5'd0, 32'h0000_0001, 32'd0);
    alu("andi", 5'd5, 6'b000101, 32'h0000_0003, 5'd0, 32'h0000_0001, 32'd0);

    // Illegal ops
    alu("ill_3f", 5'd9, 6'b111111, 32'h0000_0001, 5'd0, 32'd0, 32'd1);
    alu("ill_13", 5'd9, 6'b010011, 32'h0000_0001, 5'd0, 32'd0, 32'd1);

    // Reset beats a same-cycle write
    wr(5'd3, 32'h0000_0055);
    rs1 = 5'd3; #1;
    check("x3_pre", rv1, 32'h0000_0055);
    reset = 1'b1; rd = 5'd3; rf_indata = 32'h0000_00AA; regwrite = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; regwrite = 1'b0;
    rs1 = 5'd3; rs2 = 5'd9; #1;
    check("rst_x3", rv1, 32'd0);
    check("rst_x9", rv2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
